pe1_stage_sched: RTL and testbench

- Sequences the PE1 add/sub butterfly across all log2(N) stages of an in-place NTT/INTT over coefficient memory.
- Generates paired read addresses, the PE1 mode controls, and matching write-back addresses and enables, delayed by memory-read plus PE1 pipeline latency.
- Inserts a drain gap between stages so no stage reads a word before the previous stage has written it back.
- Sits between the top-level NTT FSM (start/done) and the dual-port coefficient RAM plus PE1.

---
 rtl/pe1_stage_sched.sv | 155 +++++++++++++++
 tb/tb_pe1_stage_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe1_stage_sched.sv
// Stage scheduler for the PE1 add/sub butterfly across all stages of an in-place NTT/INTT.
// Emits paired read addresses and replays them through a WB_LAT delay line as write-back addresses.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one butterfly read per cycle, j = 0..N/2-1
// DRAIN | reads paused until the stage's last write-back lands
// FIN   | one-cycle done pulse
module pe1_stage_sched #(
  parameter int N_LOG  = 9,
  parameter int RD_LAT = 1,
  parameter int PE_LAT = 6,
  parameter int AW     = N_LOG
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mode_intt,
  output logic                         rd_en,
  output logic [AW-1:0]                rd_addr_u,
  output logic [AW-1:0]                rd_addr_v,
  output logic                         sel,
  output logic                         sel_ntt,
  output logic                         wr_en,
  output logic [AW-1:0]                wr_addr_u,
  output logic [AW-1:0]                wr_addr_v,
  output logic [$clog2(N_LOG+1)-1:0]   stage,
  output logic                         busy,
  output logic                         done
);

  localparam int WB_LAT = RD_LAT + PE_LAT;
  localparam int SW     = $clog2(N_LOG + 1);
  localparam int CW     = $clog2(WB_LAT + 1);
  localparam logic [AW-1:0] J_LAST     = AW'((1 << (N_LOG - 1)) - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(N_LOG - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   j;
  logic [SW-1:0]   stage_q;
  logic [CW-1:0]   cnt;
  logic            mode_q;

  logic [SW-1:0]   half_log;
  logic [AW-1:0]   half, mask, base;

  logic            dl_en [WB_LAT];
  logic [AW-1:0]   dl_u  [WB_LAT];
  logic [AW-1:0]   dl_v  [WB_LAT];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (j == J_LAST) state_nx = DRAIN;
      DRAIN:   if (cnt == CW'(1)) state_nx = (stage_q == STAGE_LAST) ? FIN : RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      j       <= '0;
      stage_q <= '0;
      cnt     <= '0;
      mode_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mode_q  <= mode_intt;
          stage_q <= '0;
          j       <= '0;
        end
        RUN: begin
          j <= j + AW'(1);
          if (j == J_LAST) cnt <= CW'(WB_LAT);
        end
        DRAIN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1) && stage_q != STAGE_LAST) begin
            stage_q <= stage_q + SW'(1);
            j       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Butterfly span is 2^half_log; insert a zero at that bit of j to get the upper operand.
  always_comb begin
    half_log = mode_q ? stage_q : (STAGE_LAST - stage_q);
    half     = AW'(1) << half_log;
    mask     = half - AW'(1);
    base     = ((j & ~mask) << 1) | (j & mask);
  end

  always_comb begin
    rd_en     = 1'b0;
    rd_addr_u = '0;
    rd_addr_v = '0;
    busy      = 1'b0;
    done      = 1'b0;
    stage     = '0;
    sel       = mode_q;
    sel_ntt   = (state != IDLE) && !mode_q;
    case (state)
      RUN: begin
        rd_en     = 1'b1;
        rd_addr_u = base;
        rd_addr_v = base | half;
        busy      = 1'b1;
        stage     = stage_q;
      end
      DRAIN: begin
        busy  = 1'b1;
        stage = stage_q;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  // Clearing the delay line on reset kills any write-back still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WB_LAT; i++) begin
        dl_en[i] <= 1'b0;
        dl_u[i]  <= '0;
        dl_v[i]  <= '0;
      end
    end else begin
      dl_en[0] <= rd_en;
      dl_u[0]  <= rd_addr_u;
      dl_v[0]  <= rd_addr_v;
      for (int i = 1; i < WB_LAT; i++) begin
        dl_en[i] <= dl_en[i-1];
        dl_u[i]  <= dl_u[i-1];
        dl_v[i]  <= dl_v[i-1];
      end
    end
  end

  assign wr_en     = dl_en[WB_LAT-1];
  assign wr_addr_u = dl_u[WB_LAT-1];
  assign wr_addr_v = dl_v[WB_LAT-1];

endmodule

// File: tb/tb_pe1_stage_sched.sv
// Bench for pe1_stage_sched: an N=8 and an N=512 instance checked each cycle against a schedule
// model, plus table spot checks, abort/restart sequences and a per-stage write coverage scoreboard.
module tb_pe1_stage_sched;
  localparam int WB = 7;

  typedef struct packed {
    logic       rd_en;
    logic [9:0] ru;
    logic [9:0] rv;
    logic       wr_en;
    logic [9:0] wu;
    logic [9:0] wv;
    logic       busy;
    logic       done;
    logic       sel;
    logic       sel_ntt;
    logic [4:0] stage;
  } outs_t;

  typedef struct {
    int    cyc;
    bit    intt;
    outs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1, start3 = 1'b0, mode3 = 1'b0, start9 = 1'b0, mode9 = 1'b0;

  logic       rd_en3, sel3, sel_ntt3, wr_en3, busy3, done3;
  logic [2:0] rd_u3, rd_v3, wr_u3, wr_v3;
  logic [1:0] stage3;
  logic       rd_en9, sel9, sel_ntt9, wr_en9, busy9, done9;
  logic [8:0] rd_u9, rd_v9, wr_u9, wr_v9;
  logic [3:0] stage9;

  always #5 clk = ~clk;

  pe1_stage_sched #(.N_LOG(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .mode_intt(mode3),
    .rd_en(rd_en3), .rd_addr_u(rd_u3), .rd_addr_v(rd_v3),
    .sel(sel3), .sel_ntt(sel_ntt3),
    .wr_en(wr_en3), .wr_addr_u(wr_u3), .wr_addr_v(wr_v3),
    .stage(stage3), .busy(busy3), .done(done3)
  );

  pe1_stage_sched dut9 (
    .clk(clk), .rst(rst), .start(start9), .mode_intt(mode9),
    .rd_en(rd_en9), .rd_addr_u(rd_u9), .rd_addr_v(rd_v9),
    .sel(sel9), .sel_ntt(sel_ntt9),
    .wr_en(wr_en9), .wr_addr_u(wr_u9), .wr_addr_v(wr_v9),
    .stage(stage9), .busy(busy9), .done(done9)
  );

  int    gc = 0, n_vec = 0, n_mis = 0;
  bit    chk_on = 1'b0;
  bit    vld [2];
  int    t0s [2];
  bit    mls [2];
  int    rec_idx = -1, rec_t0 = 0;
  outs_t tr [0:4][0:40];
  bit    sb_on = 1'b0;
  int    wcnt9 = 0, done9_at = -1;
  int    cnt9 [0:8][0:511];
  vec_t  tbl [$];

  function automatic void pair(input int nlog, input bit intt, input int s, input int j,
                               output int u, output int w);
    int half;
    half = intt ? (1 << s) : ((1 << nlog) >> (s + 1));
    u = 2 * (j / half) * half + (j % half);
    w = u + half;
  endfunction

  // Schedule derived directly from start time: stage period is N/2 reads plus WB drain cycles.
  function automatic outs_t model(input int nlog, input bit v, input int t0, input bit ml, input int c);
    outs_t o;
    int nh, p, rel, rw, u, w;
    o = '0;
    nh = 1 << (nlog - 1);
    p = nh + WB;
    rel = c - t0 - 1;
    rw = rel - WB;
    o.sel = ml;
    if (v) begin
      if (rel >= 0 && rel < nlog * p) begin
        o.busy = 1'b1;
        o.stage = 5'(rel / p);
        if (rel % p < nh) begin
          pair(nlog, ml, rel / p, rel % p, u, w);
          o.rd_en = 1'b1;
          o.ru = 10'(u);
          o.rv = 10'(w);
        end
      end
      if (rel == nlog * p) o.done = 1'b1;
      if (rel >= 0 && rel <= nlog * p) o.sel_ntt = !ml;
      if (rw >= 0 && rw < nlog * p && rw % p < nh) begin
        pair(nlog, ml, rw / p, rw % p, u, w);
        o.wr_en = 1'b1;
        o.wu = 10'(u);
        o.wv = 10'(w);
      end
    end
    return o;
  endfunction

  function automatic bit idle(input int k, input int c);
    int nlog, p;
    nlog = (k == 0) ? 3 : 9;
    p = (1 << (nlog - 1)) + WB;
    return !vld[k] || (c >= t0s[k] + nlog * p + 2);
  endfunction

  function automatic vec_t mk(input int cyc, input bit intt, input bit rd, input int u, input int v,
                              input bit wr, input int wu, input int wv, input bit bsy, input bit dn,
                              input int stg);
    vec_t r;
    r.cyc = cyc;
    r.intt = intt;
    r.exp = '0;
    r.exp.rd_en = rd;
    r.exp.ru = 10'(u);
    r.exp.rv = 10'(v);
    r.exp.wr_en = wr;
    r.exp.wu = 10'(wu);
    r.exp.wv = 10'(wv);
    r.exp.busy = bsy;
    r.exp.done = dn;
    r.exp.sel = intt;
    r.exp.sel_ntt = !intt && (bsy || dn);
    r.exp.stage = 5'(stg);
    return r;
  endfunction

  task automatic check(input string name, input int c, input outs_t g, input outs_t e);
    n_vec++;
    if (g !== e) begin
      n_mis++;
      $display("FAIL %s cyc=%0d got{rd=%0b u=%0d v=%0d wr=%0b u=%0d v=%0d busy=%0b done=%0b sel=%0b/%0b stg=%0d} exp{rd=%0b u=%0d v=%0d wr=%0b u=%0d v=%0d busy=%0b done=%0b sel=%0b/%0b stg=%0d}",
               name, c, g.rd_en, g.ru, g.rv, g.wr_en, g.wu, g.wv, g.busy, g.done, g.sel, g.sel_ntt, g.stage,
               e.rd_en, e.ru, e.rv, e.wr_en, e.wu, e.wv, e.busy, e.done, e.sel, e.sel_ntt, e.stage);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // One clock cycle: check this cycle's outputs, then drive inputs and advance the model.
  task automatic cyc(input bit r, input bit s3, input bit m3, input bit s9, input bit m9);
    outs_t g3, g9, e3, e9;
    int st;
    @(negedge clk);
    g3 = '0;
    g3.rd_en = rd_en3; g3.ru = 10'(rd_u3); g3.rv = 10'(rd_v3);
    g3.wr_en = wr_en3; g3.wu = 10'(wr_u3); g3.wv = 10'(wr_v3);
    g3.busy = busy3; g3.done = done3; g3.sel = sel3; g3.sel_ntt = sel_ntt3; g3.stage = 5'(stage3);
    g9 = '0;
    g9.rd_en = rd_en9; g9.ru = 10'(rd_u9); g9.rv = 10'(rd_v9);
    g9.wr_en = wr_en9; g9.wu = 10'(wr_u9); g9.wv = 10'(wr_v9);
    g9.busy = busy9; g9.done = done9; g9.sel = sel9; g9.sel_ntt = sel_ntt9; g9.stage = 5'(stage9);
    e3 = model(3, vld[0], t0s[0], mls[0], gc);
    e9 = model(9, vld[1], t0s[1], mls[1], gc);
    if (chk_on) begin
      check("n8_model", gc, g3, e3);
      check("n512_model", gc, g9, e9);
    end
    if (rec_idx >= 0 && gc - rec_t0 >= 0 && gc - rec_t0 <= 40) tr[rec_idx][gc - rec_t0] = g3;
    if (sb_on && g9.wr_en) begin
      st = wcnt9 / 256;
      if (st < 9) begin
        cnt9[st][g9.wu[8:0]]++;
        cnt9[st][g9.wv[8:0]]++;
      end
      wcnt9++;
    end
    if (sb_on && g9.done && done9_at < 0) done9_at = gc - t0s[1];
    rst = r; start3 = s3; mode3 = m3; start9 = s9; mode9 = m9;
    if (r) begin
      vld[0] = 1'b0; mls[0] = 1'b0;
      vld[1] = 1'b0; mls[1] = 1'b0;
    end else begin
      if (s3 && idle(0, gc)) begin vld[0] = 1'b1; t0s[0] = gc; mls[0] = m3; end
      if (s9 && idle(1, gc)) begin vld[1] = 1'b1; t0s[1] = gc; mls[1] = m9; end
    end
    gc++;
  endtask

  initial begin
    int bad;
    // NTT, N=8
    tbl.push_back(mk( 1, 0, 1, 0, 4, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk( 4, 0, 1, 3, 7, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk( 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk( 8, 0, 0, 0, 0, 1, 0, 4, 1, 0, 0));
    tbl.push_back(mk(11, 0, 0, 0, 0, 1, 3, 7, 1, 0, 0));
    tbl.push_back(mk(12, 0, 1, 0, 2, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(14, 0, 1, 4, 6, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(15, 0, 1, 5, 7, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(19, 0, 0, 0, 0, 1, 0, 2, 1, 0, 1));
    tbl.push_back(mk(23, 0, 1, 0, 1, 0, 0, 0, 1, 0, 2));
    tbl.push_back(mk(26, 0, 1, 6, 7, 0, 0, 0, 1, 0, 2));
    tbl.push_back(mk(33, 0, 0, 0, 0, 1, 6, 7, 1, 0, 2));
    tbl.push_back(mk(34, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(35, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // INTT, N=8
    tbl.push_back(mk( 1, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk( 4, 1, 1, 6, 7, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(12, 1, 1, 0, 2, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(23, 1, 1, 0, 4, 0, 0, 0, 1, 0, 2));
    tbl.push_back(mk(26, 1, 1, 3, 7, 0, 0, 0, 1, 0, 2));
    tbl.push_back(mk(30, 1, 0, 0, 0, 1, 0, 4, 1, 0, 2));
    tbl.push_back(mk(34, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    cyc(1, 0, 0, 0, 0);
    chk_on = 1'b1;
    repeat (2) cyc(1, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);

    rec_idx = 0; rec_t0 = gc;
    cyc(0, 1, 0, 0, 0);
    repeat (40) cyc(0, 0, 0, 0, 0);

    rec_idx = 1; rec_t0 = gc;
    cyc(0, 1, 1, 0, 0);
    repeat (40) cyc(0, 0, 0, 0, 0);

    // Second start mid-run (with the opposite mode) must be ignored.
    rec_idx = 2; rec_t0 = gc;
    for (int i = 0; i <= 40; i++) cyc(0, (i == 0) || (i == 10), i == 10, 0, 0);

    // Reset while stage-0 write-backs are in flight.
    rec_idx = 3; rec_t0 = gc;
    for (int i = 0; i <= 40; i++) cyc(i == 9, i == 0, 0, 0, 0);

    rec_idx = 4; rec_t0 = gc;
    cyc(0, 1, 0, 0, 0);
    repeat (40) cyc(0, 0, 0, 0, 0);
    rec_idx = -1;

    // start coincident with rst: rst wins.
    cyc(1, 1, 1, 1, 1);
    repeat (5) cyc(0, 0, 0, 0, 0);

    for (int s = 0; s < 9; s++)
      for (int a = 0; a < 512; a++) cnt9[s][a] = 0;
    sb_on = 1'b1; wcnt9 = 0; done9_at = -1;
    cyc(0, 0, 0, 1, 0);
    repeat (2380) cyc(0, 0, 0, 0, 0);
    sb_on = 1'b0;
    check_int("n512_done_latency", done9_at, 2368);
    check_int("n512_total_writes", wcnt9, 9 * 256);
    for (int s = 0; s < 9; s++) begin
      bad = 0;
      for (int a = 0; a < 512; a++) if (cnt9[s][a] != 1) bad++;
      check_int($sformatf("n512_stage%0d_addrs_not_once", s), bad, 0);
    end

    repeat (15000)
      cyc($urandom_range(0, 999) == 0, $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)));

    for (int t = 0; t <= 4; t++) begin
      if (t == 3) continue;
      foreach (tbl[r]) begin
        if (tbl[r].intt == (t == 1))
          check($sformatf("table_run%0d", t), tbl[r].cyc, tr[t][tbl[r].cyc], tbl[r].exp);
      end
    end

    check_int("abort_wr_active_at_9", int'(tr[3][9].wr_en), 1);
    bad = 0;
    for (int i = 10; i <= 40; i++) if (tr[3][i] != '0) bad++;
    check_int("abort_quiet_cycles_nonzero", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
